// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Interface : mem_port_arbiter_if
// Brief     : Requester handshakes (core = port 0, loader = port 1) plus the
//             external memory pins served by mem_port_arbiter.
//             With MEM_PORT_ARBITER_LOCK_EN defined, lock0/lock1 are added.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // Port 0 (stack-machine core)
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic [DATA_W-1:0] rdata0;
    logic              rvalid0;

    // Port 1 (host/debug loader)
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid1;

`ifdef MEM_PORT_ARBITER_LOCK_EN
    logic              lock0;
    logic              lock1;
`endif

    // External memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
`ifdef MEM_PORT_ARBITER_LOCK_EN
        input  lock0, lock1,
`endif
        input  req0, we0, addr0, wdata0,
        output gnt0, rdata0, rvalid0,
        input  req1, we1, addr1, wdata1,
        output gnt1, rdata1, rvalid1,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory-model side
    modport master (
`ifdef MEM_PORT_ARBITER_LOCK_EN
        output lock0, lock1,
`endif
        output req0, we0, addr0, wdata0,
        input  gnt0, rdata0, rvalid0,
        output req1, we1, addr1, wdata1,
        input  gnt1, rdata1, rvalid1,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares the single external memory port between the stack-machine
//            core (port 0) and the host/debug loader (port 1). Requests are
//            accepted by a req/gnt handshake, arbitrated round-robin, issued
//            as one memory access each; read data returns RD_LATENCY cycles
//            after the issue cycle.
//            Optional macro MEM_PORT_ARBITER_LOCK_EN: lock0/lock1 let the
//            current owner keep the port for its next request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
) (
    input  wire logic         clock,
    input  wire logic         reset,
    mem_port_arbiter_if.slave bus
);

    localparam int             c_cnt_w  = 4;
    localparam logic [c_cnt_w-1:0] c_rd_lat = c_cnt_w'(RD_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic               r_owner;        // port that owns the transaction in flight
    logic               r_last_winner;  // port that won the previous acceptance
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [c_cnt_w-1:0] r_cnt;
    logic [DATA_W-1:0]  r_rdata0;
    logic [DATA_W-1:0]  r_rdata1;
    logic               r_rvalid0;
    logic               r_rvalid1;

    logic               w_eff_req0;
    logic               w_eff_req1;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_accept;
    logic               w_rd_done;

`ifdef MEM_PORT_ARBITER_LOCK_EN
    logic               r_lock;

    // A locked owner hides the other port's request from arbitration.
    assign w_eff_req0 = bus.req0 && !(r_lock &&  r_owner);
    assign w_eff_req1 = bus.req1 && !(r_lock && !r_owner);
`else
    assign w_eff_req0 = bus.req0;
    assign w_eff_req1 = bus.req1;
`endif

    assign w_accept  = w_gnt0 || w_gnt1;
    assign w_rd_done = (r_state == WAIT) && (r_cnt == 4'd1);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and combinational grants (grants only exist in IDLE).
    always_comb begin
        w_next_state = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!reset) begin
                    // On contention the port that did not win last time goes.
                    w_gnt0 = w_eff_req0 && (!w_eff_req1 ||  r_last_winner);
                    w_gnt1 = w_eff_req1 && (!w_eff_req0 || !r_last_winner);
                end
                if (w_gnt0 || w_gnt1) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_next_state = r_we ? IDLE : WAIT;
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Capture the winning request; address/data also drive the memory pins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner       <= 1'b0;
            r_last_winner <= 1'b1;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
        end else if (w_accept) begin
            r_owner       <= w_gnt1;
            r_last_winner <= w_gnt1;
            r_we          <= w_gnt1 ? bus.we1    : bus.we0;
            r_addr        <= w_gnt1 ? bus.addr1  : bus.addr0;
            r_wdata       <= w_gnt1 ? bus.wdata1 : bus.wdata0;
        end
    end

`ifdef MEM_PORT_ARBITER_LOCK_EN
    // Lock is re-sampled at every acceptance, so an unlocked request releases it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lock <= 1'b0;
        end else if (w_accept) begin
            r_lock <= w_gnt1 ? bus.lock1 : bus.lock0;
        end
    end
`endif

    // Read latency countdown: loaded in ISSUE for reads, counts down in WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((r_state == ISSUE) && !r_we) begin
            r_cnt <= c_rd_lat;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Return read data to the owner; rdata holds until that port's next read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_rd_done && !r_owner;
            r_rvalid1 <= w_rd_done &&  r_owner;
            if (w_rd_done && !r_owner) begin
                r_rdata0 <= bus.mem_rdata;
            end
            if (w_rd_done && r_owner) begin
                r_rdata1 <= bus.mem_rdata;
            end
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.rvalid0   = r_rvalid0;
    assign bus.rvalid1   = r_rvalid1;
    assign bus.mem_req   = (r_state == ISSUE);
    assign bus.mem_we    = (r_state == ISSUE) && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 8-bit external memory port between two requesters: port 0 is the stack-machine core and port 1 is the host/debug loader.
- Requests are accepted through a req/gnt handshake and arbitrated round-robin.
- Each accepted request is issued as one memory access. Read data is returned to the winning port after a fixed memory read latency.
- The block sits between the core/loader and the top-level mem_addr/data_in/data_out pins.

Parameters:
- RD_LATENCY, 1, cycles from the ISSUE cycle to mem_rdata being valid. Legal range 1..15.
- ADDR_W, 8, address width.
- DATA_W, 8, data width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request. Held with we0/addr0/wdata0 stable until gnt0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 request accepted this cycle.
- rdata0  out  DATA_W  port 0 read data, registered. Holds its value until the next port 0 read.
- rvalid0  out  1  one-cycle pulse: rdata0 updated.
- req1, we1, addr1, wdata1, gnt1, rdata1, rvalid1: same definitions as port 0, for port 1.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - gnt is combinational and asserted only in IDLE. At most one gnt is high per cycle.
  - Only req0: gnt0. Only req1: gnt1.
  - Both requesting: grant the port that did not win the previous acceptance (the last_winner pointer).
  - On the accepting edge: capture owner, we, addr and wdata; update last_winner; go to ISSUE.
  - No req: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_req=1; mem_we, mem_addr and mem_wdata come from the captured registers.
  - Write: return to IDLE. No rvalid is generated.
  - Read: load the countdown with RD_LATENCY; go to WAIT.
- WAIT:
  - Decrement the countdown each cycle. mem_req=0.
  - On the edge ending the cycle with countdown==1: register mem_rdata into the owner's rdata, pulse the owner's rvalid for the following cycle, go to IDLE.
- Timing and throughput:
  - Write: 2 cycles per transaction (IDLE accept + ISSUE).
  - Read: 2+RD_LATENCY cycles per transaction. rvalid coincides with the next IDLE cycle, which may accept a new request in that same cycle.
- Memory outputs outside ISSUE: mem_req=0, mem_we=0; mem_addr and mem_wdata hold their last values.
- Requester rules:
  - req may drop before gnt; nothing is issued in that case.
  - Changing addr/we/wdata while req is high and gnt is low is illegal; the bench must not do it.
- Reset values:
  - Outputs: gnt0/1=0, rvalid0/1=0, rdata0/1=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - State IDLE; last_winner=1, so port 0 wins the first contention.
- Reset during ISSUE/WAIT: the transaction is aborted, no rvalid is generated, and the FSM returns to IDLE asynchronously.
- No wrap-around concerns: addresses pass through unchanged.

Optional Feature:
- Macro MEM_PORT_ARBITER_LOCK_EN.
- Defined:
  - Adds input ports lock0 and lock1 (1 bit each), sampled with the request at acceptance.
  - If the owner's lock was high, the next IDLE arbitration considers only that owner's req; the other port's req is ignored.
  - Ownership continues until the owner has a request accepted with lock low.
  - Used for read-modify-write sequences such as a loader verify-after-write.
  - Reset clears the lock.
- Not defined: lock ports are absent; pure round-robin as above.

Test Plan:
- Single read, RD_LATENCY=1: req0, we0=0, addr0=0x20, memory returns 0x5A. Required: gnt0 in cycle 0; mem_req=1 with mem_addr=0x20 in cycle 1; rvalid0=1 with rdata0=0x5A in cycle 3.
- Single write: req1, we1=1, addr1=0x80, wdata1=0xC3. Required: gnt1 in cycle 0; cycle 1 has mem_req=1, mem_we=1, mem_addr=0x80, mem_wdata=0xC3; rvalid1 never asserts.
- Contention: req0 and req1 held continuously, both reads. Required: gnt order 0,1,0,1 after reset, with no cycle where both gnt are high.
- Latency: RD_LATENCY=3, read addr0=0x10, memory returns 0x77. Required: rvalid0 exactly 5 cycles after gnt0, rdata0=0x77; gnt1 withheld until rvalid0's cycle.
- Reset during WAIT: reset asserted in WAIT. Required: all outputs 0 immediately, no rvalid afterwards, and the next contention grants port 0.
- Lock (MEM_PORT_ARBITER_LOCK_EN): port 1 read 0x40 with lock1=1, then write 0x40 with lock1=0, while req0 is held throughout. Required: both port 1 transactions are granted before gnt0.
